// File: rtl/ariane_pkg.sv
// Shared types for the commit trace transmitter.
//   commit_trace_rec_t : one trace record (kind, priv, rd, is_fp, pc, data)
//   KIND_*             : record kind encoding
//   CAUSE_BREAKPOINT   : exception cause that is hidden while in debug mode
package ariane_pkg;

    localparam logic [1:0]  KIND_INSTR       = 2'd1;
    localparam logic [1:0]  KIND_INSTR_WB    = 2'd2;
    localparam logic [1:0]  KIND_EXC         = 2'd3;
    localparam logic [63:0] CAUSE_BREAKPOINT = 64'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  priv;
        logic [4:0]  rd;
        logic        is_fp;
        logic [63:0] pc;
        logic [63:0] data;
    } commit_trace_rec_t;

endpackage

// File: rtl/commit_trace_fifo.sv
// Record FIFO: up to NR_PUSH records written per cycle, one read per cycle,
// first-word-fall-through head.
//   clk_i, rst_ni : clock, async active-low reset
//   push_cnt_i    : number of entries of push_rec_i to write (lowest first)
//   push_rec_i    : compacted records to write
//   pop_i         : consume the head entry
//   count_o       : occupancy
//   head_o        : head entry, '0 when empty
// The caller guarantees push_cnt_i fits in the free space after the pop.
module commit_trace_fifo
    import ariane_pkg::*;
#(
    parameter  int unsigned DEPTH   = 8,
    parameter  int unsigned NR_PUSH = 3,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned CW      = AW + 1,
    localparam int unsigned PW      = $clog2(NR_PUSH + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [PW-1:0]                   push_cnt_i,
    input  commit_trace_rec_t [NR_PUSH-1:0] push_rec_i,
    input  logic                            pop_i,
    output logic [CW-1:0]                   count_o,
    output commit_trace_rec_t               head_o
);

    commit_trace_rec_t mem_q [DEPTH];
    logic [AW-1:0]     rptr_q, wptr_q;
    logic [CW-1:0]     count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            rptr_q  <= rptr_q + AW'(pop_i);
            wptr_q  <= wptr_q + AW'(push_cnt_i);
            count_q <= count_q - CW'(pop_i) + CW'(push_cnt_i);
        end
    end

    // Storage is not reset; an empty FIFO never exposes it.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NR_PUSH); i++) begin
            if (i < int'(push_cnt_i)) begin
                mem_q[wptr_q + AW'(i)] <= push_rec_i[i];
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem_q[rptr_q] : '0;

endmodule

// File: rtl/commit_trace_tx.sv
// Commit trace transmitter: turns retiring instructions and commit-time
// exceptions into trace records, queues them, and streams them out with a
// valid/ready handshake. A cycle's records are queued all-or-nothing;
// rejected records are counted in a saturating drop counter.
//   commit_*_i, we_*_i, wdata_i : per-port commit information (flattened)
//   priv_lvl_i, debug_mode_i    : core state attached to / filtering records
//   ex_valid_i/cause_i/tval_i   : exception at commit
//   trace_valid_o/ready_i/rec_o : record stream (FWFT head)
//   drop_cnt_o, overflow_o      : saturating drop count, sticky drop flag
module commit_trace_tx
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned NR_COMMIT_PORTS = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic [NR_COMMIT_PORTS-1:0]    commit_ack_i,
    input  logic [NR_COMMIT_PORTS*64-1:0] commit_pc_i,
    input  logic [NR_COMMIT_PORTS*5-1:0]  commit_rd_i,
    input  logic [NR_COMMIT_PORTS-1:0]    we_gpr_i,
    input  logic [NR_COMMIT_PORTS-1:0]    we_fpr_i,
    input  logic [NR_COMMIT_PORTS*64-1:0] wdata_i,
    input  logic [1:0]                   priv_lvl_i,
    input  logic                         debug_mode_i,
    input  logic                         ex_valid_i,
    input  logic [63:0]                  ex_cause_i,
    input  logic [63:0]                  ex_tval_i,
    output logic                         trace_valid_o,
    input  logic                         trace_ready_i,
    output commit_trace_rec_t            trace_rec_o,
    output logic [15:0]                  drop_cnt_o,
    output logic                         overflow_o
);

    localparam int unsigned NR_PUSH = NR_COMMIT_PORTS + 1;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned PW      = $clog2(NR_PUSH + 1);

    commit_trace_rec_t [NR_PUSH-1:0] recs;
    logic [PW-1:0]                   n_rec;
    logic [PW-1:0]                   push_cnt;
    logic [CW-1:0]                   count;
    logic [CW:0]                     free_slots;
    logic                            pop, fits, do_drop;
    logic [16:0]                     drop_sum;
    logic [15:0]                     drop_cnt_q, drop_cnt_d;
    logic                            overflow_q, overflow_d;

    // Records are packed densely: acked ports in port order, then the exception.
    always_comb begin
        recs  = '0;
        n_rec = '0;
        for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
            if (commit_ack_i[p]) begin
                recs[n_rec].priv = priv_lvl_i;
                recs[n_rec].rd   = commit_rd_i[p*5 +: 5];
                recs[n_rec].pc   = commit_pc_i[p*64 +: 64];
                if (we_gpr_i[p] || we_fpr_i[p]) begin
                    recs[n_rec].kind  = KIND_INSTR_WB;
                    recs[n_rec].is_fp = we_fpr_i[p];
                    recs[n_rec].data  = wdata_i[p*64 +: 64];
                end else begin
                    recs[n_rec].kind  = KIND_INSTR;
                end
                n_rec = n_rec + PW'(1);
            end
        end
        // Breakpoints taken in debug mode are the debugger's own traps; hide them.
        if (ex_valid_i && !(debug_mode_i && ex_cause_i == CAUSE_BREAKPOINT)) begin
            recs[n_rec].kind  = KIND_EXC;
            recs[n_rec].priv  = priv_lvl_i;
            recs[n_rec].rd    = ex_cause_i[4:0];
            recs[n_rec].is_fp = ex_cause_i[63];
            recs[n_rec].pc    = commit_pc_i[63:0];
            recs[n_rec].data  = ex_tval_i;
            n_rec = n_rec + PW'(1);
        end
    end

    assign pop        = trace_valid_o & trace_ready_i;
    // A slot freed by this cycle's pop is usable by this cycle's push.
    assign free_slots = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
    assign fits       = (CW+1)'(n_rec) <= free_slots;
    assign push_cnt   = (enable_i && fits) ? n_rec : '0;
    assign do_drop    = enable_i && (n_rec != '0) && !fits;

    assign drop_sum   = {1'b0, drop_cnt_q} + 17'(n_rec);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (do_drop) begin
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    commit_trace_fifo #(
        .DEPTH   (DEPTH),
        .NR_PUSH (NR_PUSH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_cnt_i (push_cnt),
        .push_rec_i (recs),
        .pop_i      (pop),
        .count_o    (count),
        .head_o     (trace_rec_o)
    );

    assign trace_valid_o = (count != '0);
    assign drop_cnt_o    = drop_cnt_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
module tb_commit_trace_tx;
    import ariane_pkg::*;

    localparam int DEPTH = 8;
    localparam int NR    = 2;

    logic              clk, rst_ni, enable_i;
    logic [NR-1:0]     commit_ack_i;
    logic [NR*64-1:0]  commit_pc_i;
    logic [NR*5-1:0]   commit_rd_i;
    logic [NR-1:0]     we_gpr_i, we_fpr_i;
    logic [NR*64-1:0]  wdata_i;
    logic [1:0]        priv_lvl_i;
    logic              debug_mode_i, ex_valid_i;
    logic [63:0]       ex_cause_i, ex_tval_i;
    logic              trace_valid_o, trace_ready_i;
    commit_trace_rec_t trace_rec_o;
    logic [15:0]       drop_cnt_o;
    logic              overflow_o;

    commit_trace_tx #(.DEPTH(DEPTH), .NR_COMMIT_PORTS(NR)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i),
        .commit_ack_i(commit_ack_i), .commit_pc_i(commit_pc_i), .commit_rd_i(commit_rd_i),
        .we_gpr_i(we_gpr_i), .we_fpr_i(we_fpr_i), .wdata_i(wdata_i),
        .priv_lvl_i(priv_lvl_i), .debug_mode_i(debug_mode_i),
        .ex_valid_i(ex_valid_i), .ex_cause_i(ex_cause_i), .ex_tval_i(ex_tval_i),
        .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
        .trace_rec_o(trace_rec_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of records plus drop bookkeeping.
    commit_trace_rec_t mq[$];
    int unsigned       m_drop;
    bit                m_ovf;
    commit_trace_rec_t saved_head;

    task automatic chk(input string tag, input logic [137:0] obs, input logic [137:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out();
        commit_trace_rec_t e;
        e = (mq.size() != 0) ? mq[0] : '0;
        chk("valid",    138'(trace_valid_o), 138'(mq.size() != 0));
        chk("rec",      138'(trace_rec_o),   138'(e));
        chk("drop_cnt", 138'(drop_cnt_o),    138'(m_drop));
        chk("overflow", 138'(overflow_o),    138'(m_ovf));
    endtask

    // Check current outputs, advance the model by one clock using the
    // currently driven inputs, then move to 1 time unit after the edge.
    task automatic step();
        commit_trace_rec_t nr[$];
        commit_trace_rec_t r;
        bit pop;
        int free_slots;
        chk_out();
        pop = (mq.size() != 0) && trace_ready_i;
        free_slots = DEPTH - mq.size() + int'(pop);
        if (enable_i) begin
            for (int p = 0; p < NR; p++) begin
                if (commit_ack_i[p]) begin
                    r = '0;
                    r.priv = priv_lvl_i;
                    r.rd   = commit_rd_i[p*5 +: 5];
                    r.pc   = commit_pc_i[p*64 +: 64];
                    if (we_gpr_i[p] || we_fpr_i[p]) begin
                        r.kind  = 2'd2;
                        r.is_fp = we_fpr_i[p];
                        r.data  = wdata_i[p*64 +: 64];
                    end else begin
                        r.kind = 2'd1;
                    end
                    nr.push_back(r);
                end
            end
            if (ex_valid_i && !(debug_mode_i && ex_cause_i == 64'd3)) begin
                r = '0;
                r.kind  = 2'd3;
                r.priv  = priv_lvl_i;
                r.rd    = ex_cause_i[4:0];
                r.is_fp = ex_cause_i[63];
                r.pc    = commit_pc_i[63:0];
                r.data  = ex_tval_i;
                nr.push_back(r);
            end
        end
        if (pop) void'(mq.pop_front());
        if (nr.size() != 0) begin
            if (nr.size() <= free_slots) begin
                foreach (nr[i]) mq.push_back(nr[i]);
            end else begin
                m_drop = m_drop + nr.size();
                if (m_drop > 65535) m_drop = 65535;
                m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        commit_ack_i = '0; we_gpr_i = '0; we_fpr_i = '0;
        commit_pc_i = '0; commit_rd_i = '0; wdata_i = '0;
        ex_valid_i = 1'b0; ex_cause_i = '0; ex_tval_i = '0; debug_mode_i = 1'b0;
    endtask

    task automatic set_port(input int p, input logic [63:0] pc, input logic [4:0] rd,
                            input logic gpr, input logic fpr, input logic [63:0] d);
        commit_ack_i[p]       = 1'b1;
        commit_pc_i[p*64+:64] = pc;
        commit_rd_i[p*5+:5]   = rd;
        we_gpr_i[p]           = gpr;
        we_fpr_i[p]           = fpr;
        wdata_i[p*64+:64]     = d;
    endtask

    task automatic randomize_inputs();
        commit_ack_i = 2'($urandom);
        commit_pc_i  = {$urandom, $urandom, $urandom, $urandom};
        commit_rd_i  = 10'($urandom);
        we_gpr_i     = 2'($urandom);
        we_fpr_i     = 2'($urandom);
        wdata_i      = {$urandom, $urandom, $urandom, $urandom};
        priv_lvl_i   = 2'($urandom);
        debug_mode_i = ($urandom_range(0, 3) == 0);
        ex_valid_i   = ($urandom_range(0, 3) == 0);
        ex_cause_i   = ($urandom_range(0, 1) == 0) ? 64'd3 : {$urandom, $urandom};
        ex_tval_i    = {$urandom, $urandom};
        trace_ready_i = ($urandom_range(0, 3) != 0);
        enable_i     = ($urandom_range(0, 7) != 0);
    endtask

    // Asynchronous reset pulse starting mid-cycle; returns 1 unit after an edge.
    task automatic do_reset();
        rst_ni = 1'b0;
        #2;
        mq.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
        chk_out();
        @(posedge clk);
        #1;
        chk_out();
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0; enable_i = 1'b0; trace_ready_i = 1'b0; priv_lvl_i = 2'd3;
        idle();
        m_drop = 0; m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out();
        rst_ni = 1'b1;

        // Two commits: port 0 writes back 0x55, port 1 has no write-back.
        enable_i = 1'b1; trace_ready_i = 1'b1;
        set_port(0, 64'h8000_0000, 5'd10, 1'b1, 1'b0, 64'h55);
        set_port(1, 64'h8000_0004, 5'd11, 1'b0, 1'b0, 64'hDEAD);
        step();
        idle();
        chk("first_kind", 138'(trace_rec_o.kind), 138'(2));
        chk("first_data", 138'(trace_rec_o.data), 138'(64'h55));
        step();
        chk("second_kind", 138'(trace_rec_o.kind), 138'(1));
        chk("second_data", 138'(trace_rec_o.data), 138'(0));
        step();
        step();

        // Fill to DEPTH without popping, then pop and push in the same cycle.
        trace_ready_i = 1'b0;
        for (int c = 0; c < DEPTH / 2; c++) begin
            set_port(0, {$urandom, $urandom}, 5'($urandom), 1'b1, 1'b0, {$urandom, $urandom});
            set_port(1, {$urandom, $urandom}, 5'($urandom), 1'b0, 1'b1, {$urandom, $urandom});
            step();
        end
        idle();
        trace_ready_i = 1'b1;
        set_port(0, 64'h1000, 5'd3, 1'b0, 1'b0, 64'h0);
        step();
        idle();
        chk("full_pushpop_drop", 138'(drop_cnt_o), 138'(0));
        chk("full_pushpop_ovf",  138'(overflow_o), 138'(0));

        // Full and stalled: two commits must be dropped as a unit.
        trace_ready_i = 1'b0;
        saved_head = trace_rec_o;
        set_port(0, 64'h2000, 5'd4, 1'b1, 1'b0, 64'h77);
        set_port(1, 64'h2004, 5'd5, 1'b1, 1'b0, 64'h88);
        step();
        idle();
        chk("drop_two",  138'(drop_cnt_o),  138'(2));
        chk("drop_ovf",  138'(overflow_o),  138'(1));
        chk("head_kept", 138'(trace_rec_o), 138'(saved_head));
        step();

        // Drain, then exception filtering and exception record contents.
        trace_ready_i = 1'b1;
        repeat (DEPTH + 1) step();
        debug_mode_i = 1'b1; ex_valid_i = 1'b1; ex_cause_i = 64'd3; ex_tval_i = 64'h99;
        step();
        idle();
        chk("bkpt_hidden", 138'(trace_valid_o), 138'(0));
        ex_valid_i = 1'b1; ex_cause_i = 64'h8000_0000_0000_0007; ex_tval_i = 64'h1234;
        commit_pc_i[63:0] = 64'h4000;
        step();
        idle();
        chk("exc_kind",  138'(trace_rec_o.kind),  138'(3));
        chk("exc_rd",    138'(trace_rec_o.rd),    138'(7));
        chk("exc_isfp",  138'(trace_rec_o.is_fp), 138'(1));
        chk("exc_data",  138'(trace_rec_o.data),  138'(64'h1234));
        chk("exc_pc",    138'(trace_rec_o.pc),    138'(64'h4000));
        step();

        // Randomized traffic with a reset pulse in the middle.
        for (int c = 0; c < 600; c++) begin
            randomize_inputs();
            step();
            if (c == 300) begin
                do_reset();
            end
        end
        idle();
        enable_i = 1'b1;

        // Saturate the drop counter.
        do_reset();
        trace_ready_i = 1'b0;
        for (int c = 0; c < DEPTH / 2; c++) begin
            set_port(0, {$urandom, $urandom}, 5'($urandom), 1'b0, 1'b0, 64'h0);
            set_port(1, {$urandom, $urandom}, 5'($urandom), 1'b0, 1'b0, 64'h0);
            step();
        end
        set_port(0, 64'h10, 5'd1, 1'b1, 1'b0, 64'h1);
        set_port(1, 64'h14, 5'd2, 1'b1, 1'b0, 64'h2);
        ex_valid_i = 1'b1; ex_cause_i = 64'd5; ex_tval_i = 64'h0;
        for (int c = 0; c < 21845; c++) step();
        chk("drop_at_max", 138'(drop_cnt_o), 138'(16'hFFFF));
        step();
        step();
        chk("drop_sat", 138'(drop_cnt_o), 138'(16'hFFFF));
        chk("sat_ovf",  138'(overflow_o), 138'(1));

        // Reset mid-stream clears everything.
        do_reset();
        idle();
        chk("rst_valid", 138'(trace_valid_o), 138'(0));
        chk("rst_drop",  138'(drop_cnt_o),    138'(0));
        chk("rst_ovf",   138'(overflow_o),    138'(0));
        trace_ready_i = 1'b1;
        set_port(0, 64'hABC0, 5'd9, 1'b1, 1'b0, 64'h5A5A);
        step();
        idle();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_trace_tx.md
COMMIT_TRACE_TX -- requirements
Module: commit_trace_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 8, record FIFO entries (power of two, >=4).
REQ-002 SHALL have parameter NR_COMMIT_PORTS, default 2, commit ports sampled per cycle.
REQ-003 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable_i  in  1  trace capture enable.
REQ-006 SHALL have port commit_ack_i  in  NR_COMMIT_PORTS  instruction retiring on port i.
REQ-007 SHALL have port commit_pc_i  in  NR_COMMIT_PORTS x 64  retiring PC.
REQ-008 SHALL have port commit_rd_i  in  NR_COMMIT_PORTS x 5  destination register.
REQ-009 SHALL have port we_gpr_i / we_fpr_i  in  NR_COMMIT_PORTS each  GPR/FPR write-back valid.
REQ-010 SHALL have port wdata_i  in  NR_COMMIT_PORTS x 64  write-back data.
REQ-011 SHALL have port priv_lvl_i  in  2  current privilege (riscv::priv_lvl_t).
REQ-012 SHALL have port debug_mode_i  in  1  core in debug mode.
REQ-013 SHALL have port ex_valid_i, ex_cause_i, ex_tval_i  in  1/64/64  exception at commit.
REQ-014 SHALL have port trace_valid_o  out  1  record available.
REQ-015 SHALL have port trace_ready_i  in  1  sink accepts record.
REQ-016 SHALL have port trace_rec_o  out  commit_trace_rec_t  head record.
REQ-017 SHALL have port drop_cnt_o  out  16  dropped-record count, saturating.
REQ-018 SHALL have port overflow_o  out  1  sticky: at least one drop since reset.

Function
- REQ-019 SHALL define the record as kind[1:0], priv[1:0], rd[4:0], is_fp, pc[63:0], data[63:0].
- REQ-020 SHALL encode kind as 1 = INSTR (no write-back, data=0), 2 = INSTR_WB (data=wdata_i, is_fp=we_fpr_i), 3 = EXC.
- REQ-021 SHALL set EXC record fields to pc=commit_pc_i[0], data=ex_tval_i, rd=ex_cause_i[4:0], is_fp=ex_cause_i[63].
- REQ-022 SHALL suppress an EXC record when debug_mode_i=1 and ex_cause_i=3 (BREAKPOINT).
- REQ-023 SHALL, per cycle with enable_i=1, form N records in order port 0..NR_COMMIT_PORTS-1, then EXC; N ranges 0..NR_COMMIT_PORTS+1.
- REQ-024 SHALL define free = DEPTH - count + pop, where pop = trace_valid_o & trace_ready_i in the same cycle.
- REQ-025 SHALL enqueue all N records atomically when N <= free; otherwise SHALL enqueue none and add N to drop_cnt_o.
- REQ-026 SHALL saturate drop_cnt_o at 0xFFFF and set overflow_o on the first drop.
- REQ-027 SHALL neither enqueue nor count drops when enable_i=0; queued records still drain.
- REQ-028 SHALL drive trace_valid_o = (count != 0) and trace_rec_o = head entry (first-word-fall-through), stable while valid & !ready.
- REQ-029 SHALL give latency of 1 cycle from a commit edge to trace_valid_o, and 1 record per cycle throughput.
- REQ-030 SHALL handle a simultaneous pop and push of N records in one cycle with count' = count - pop + N.
- REQ-031 SHALL wrap read/write pointers modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits wide.

Reset
- REQ-032 SHALL clear count, pointers, drop_cnt_o and overflow_o asynchronously on rst_ni=0; trace_valid_o=0 and trace_rec_o='0 during reset.
- REQ-033 SHALL discard in-flight records on reset mid-operation; first capture occurs on the first edge after deassertion.

Structure
- REQ-034 SHALL place commit_trace_rec_t and the kind encoding localparams in ariane_pkg.
- REQ-035 SHALL implement storage as sub-module commit_trace_fifo (multi-push, single-pop, FWFT); record formation and drop logic stay in the top level.

Verification
- REQ-036 SHALL cover: ack both ports, port0 we_gpr wdata=0x55, port1 no WB -> next cycles records kind 2 data 0x55, then kind 1 data 0, in order.
- REQ-037 SHALL cover: ready=0, fill DEPTH=8, then 2 commits -> no enqueue, drop_cnt_o=2, overflow_o=1, head record unchanged.
- REQ-038 SHALL cover: count=8, ready=1, 1 commit -> pop+push same cycle, count stays 8, drop_cnt_o=0.
- REQ-039 SHALL cover: ex_valid cause=3 with debug_mode=1 -> no EXC record; cause=0x8000000000000007, tval=0x1234 -> kind 3, rd=7, is_fp=1, data=0x1234.
- REQ-040 SHALL cover: drop_cnt_o preset by 65535 drops, further drop -> stays 0xFFFF; rst_ni pulse mid-stream -> valid=0, counters 0.
